// File: rtl/c1bias_ctrl_pkg.sv
// Shared CNN widths and the bias-ROM address helper for the C1 bias sequencer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package c1bias_ctrl_pkg;

   localparam int CNN_PARA_WIDTH = 16;
   localparam int CNN_BIAS_SIZE  = 32;
   localparam int ADDR_W         = $clog2(CNN_BIAS_SIZE);

   // Unsigned 5-bit ROM address; the legal parameter range keeps base+ch within 31.
   function automatic logic [ADDR_W-1:0] bias_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [ADDR_W-1:0] ch);
      return base + ch;
   endfunction

endpackage

// File: rtl/c1bias_ctrl.sv
// Reads CH_NUM bias words from the bias ROM and hands them one at a time to the conv datapath.
// Latency: first bias_valid 3 cycles after start; 3 cycles per bias when bias_ready is held high.
// Backpressure: a presented bias is held unchanged until bias_ready; no prefetch of the next word.
module c1bias_ctrl
   import c1bias_ctrl_pkg::*;
#(
   parameter int CH_NUM    = 6,
   parameter int BASE_ADDR = 0
)
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic [ADDR_W-1:0]         rom_raddr,
   input  logic [CNN_PARA_WIDTH-1:0] rom_dout,
   output logic                      bias_valid,
   input  logic                      bias_ready,
   output logic [CNN_PARA_WIDTH-1:0] bias_data,
   output logic [ADDR_W-1:0]         bias_ch,
   output logic                      bias_last
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_CAPT  = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] LAST_CH = ADDR_W'(CH_NUM - 1);

   logic [2:0]        state;
   logic [2:0]        state_nxt;
   logic [ADDR_W-1:0] ch;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: start only matters in IDLE, ready only in HOLD.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_FETCH;
         S_FETCH: state_nxt = S_CAPT;
         S_CAPT:  state_nxt = S_HOLD;
         S_HOLD:  if (bias_ready) state_nxt = bias_last ? S_DONE : S_FETCH;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Status outputs decoded from the state.
   always_comb begin
      busy = (state != S_IDLE);
      done = (state == S_DONE);
   end

   // Channel counter, ROM address and bias output registers.
   // rom_raddr is loaded on entry to FETCH so the ROM sees it during the FETCH cycle
   // and its registered data is ready to capture in CAPT.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ch         <= '0;
         rom_raddr  <= BASE;
         bias_valid <= 1'b0;
         bias_last  <= 1'b0;
         bias_data  <= '0;
         bias_ch    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  ch        <= '0;
                  rom_raddr <= BASE;
               end
            end
            S_CAPT: begin
               bias_data  <= rom_dout;
               bias_ch    <= ch;
               bias_valid <= 1'b1;
               bias_last  <= (ch == LAST_CH);
            end
            S_HOLD: begin
               if (bias_ready) begin
                  bias_valid <= 1'b0;
                  bias_last  <= 1'b0;
                  if (!bias_last) begin
                     ch        <= ch + 1'b1;
                     rom_raddr <= bias_addr(BASE, ch + 1'b1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
